// File: rtl/multi_ch_prio_fifo.sv
// Multi-channel synchronous FIFO: NUM_CH independent write queues drained through
// one registered read port, with strict-priority or round-robin read arbitration.
module multi_ch_prio_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int ARB_MODE   = 0,
    parameter int AF_THRESH  = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0]                wr_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     din,
    input  logic                             rd_en,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             dout_valid,
    output logic [CH_W-1:0]                  dout_ch,
    output logic [NUM_CH-1:0]                empty,
    output logic [NUM_CH-1:0]                full,
    output logic [NUM_CH-1:0]                almost_full,
    output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] count,
    output logic [NUM_CH-1:0]                overflow,
    output logic                             underflow
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         wr_ptr [NUM_CH];
    logic [PW-1:0]         rd_ptr [NUM_CH];
    logic [DATA_WIDTH-1:0] mem    [NUM_CH][DEPTH];
    logic [CH_W-1:0]       last_grant;
    logic [CH_W-1:0]       grant;
    logic                  grant_vld;
    logic [CH_W-1:0]       rr_idx;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_flags
        logic [PW-1:0] occ;
        assign occ            = wr_ptr[i] - rd_ptr[i];
        assign empty[i]       = (wr_ptr[i] == rd_ptr[i]);
        assign full[i]        = (wr_ptr[i][ADDR_WIDTH] != rd_ptr[i][ADDR_WIDTH]) &&
                                (wr_ptr[i][ADDR_WIDTH-1:0] == rd_ptr[i][ADDR_WIDTH-1:0]);
        assign almost_full[i] = (occ >= PW'(AF_THRESH));
        assign count[i*PW +: PW] = occ;
    end

    // Loops run from the far end so the last hit is the highest-precedence channel.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        rr_idx    = '0;
        if (ARB_MODE == 0) begin
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                if (!empty[CH_W'(c)]) begin
                    grant     = CH_W'(c);
                    grant_vld = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                rr_idx = CH_W'((int'(last_grant) + k) % NUM_CH);
                if (!empty[rr_idx]) begin
                    grant     = rr_idx;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            overflow   <= '0;
            underflow  <= 1'b0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else begin
            dout_valid <= 1'b0;
            overflow   <= wr_en & full;
            underflow  <= rd_en & (&empty);
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_en[i] && !full[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
            end
            if (rd_en && grant_vld) begin
                dout           <= mem[grant][rd_ptr[grant][ADDR_WIDTH-1:0]];
                dout_ch        <= grant;
                dout_valid     <= 1'b1;
                rd_ptr[grant]  <= rd_ptr[grant] + PW'(1);
                last_grant     <= grant;
            end
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en[i] && !full[i]) begin
                mem[i][wr_ptr[i][ADDR_WIDTH-1:0]] <= din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_multi_ch_prio_fifo.sv
// Bench for multi_ch_prio_fifo: strict-priority and round-robin instances share one
// stimulus stream; each is checked against a queue-based model and a read scoreboard.
module tb_multi_ch_prio_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  wr_en = '0;
    logic [63:0] din = '0;
    logic        rd_en = 1'b0;

    logic [1:0][15:0] dout_w;
    logic [1:0]       dout_valid_w;
    logic [1:0][1:0]  dout_ch_w;
    logic [1:0][3:0]  empty_w;
    logic [1:0][3:0]  full_w;
    logic [1:0][3:0]  af_w;
    logic [1:0][15:0] count_w;
    logic [1:0][3:0]  overflow_w;
    logic [1:0]       underflow_w;

    multi_ch_prio_fifo #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(3), .NUM_CH(4), .CH_W(2),
                         .ARB_MODE(0), .AF_THRESH(6)) u_strict (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout_w[0]), .dout_valid(dout_valid_w[0]), .dout_ch(dout_ch_w[0]),
        .empty(empty_w[0]), .full(full_w[0]), .almost_full(af_w[0]), .count(count_w[0]),
        .overflow(overflow_w[0]), .underflow(underflow_w[0]));

    multi_ch_prio_fifo #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(3), .NUM_CH(4), .CH_W(2),
                         .ARB_MODE(1), .AF_THRESH(6)) u_rr (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout_w[1]), .dout_valid(dout_valid_w[1]), .dout_ch(dout_ch_w[1]),
        .empty(empty_w[1]), .full(full_w[1]), .almost_full(af_w[1]), .count(count_w[1]),
        .overflow(overflow_w[1]), .underflow(underflow_w[1]));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] data;
    } rd_item_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] mq [2][4][$];
    rd_item_t    sb [2][$];
    int          lg [2];
    logic [15:0] m_dout [2];
    logic [1:0]  m_ch [2];
    logic        exp_valid [2];
    logic        exp_udf [2];
    logic [3:0]  exp_ovf [2];

    task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, m, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 4; c++) mq[m][c].delete();
            sb[m].delete();
            lg[m]        = 3;
            m_dout[m]    = '0;
            m_ch[m]      = '0;
            exp_valid[m] = 1'b0;
            exp_udf[m]   = 1'b0;
            exp_ovf[m]   = '0;
        end
    endtask

    // Reference: one queue per channel; reads see occupancy from before the edge.
    task automatic model_step(input logic [3:0] wr, input logic [63:0] d, input logic rd);
        for (int m = 0; m < 2; m++) begin
            int       sz [4];
            int       g;
            int       c;
            rd_item_t it;
            for (int k = 0; k < 4; k++) sz[k] = mq[m][k].size();
            exp_valid[m] = 1'b0;
            exp_udf[m]   = 1'b0;
            exp_ovf[m]   = '0;
            g = -1;
            if (rd) begin
                for (int k = 0; k < 4; k++) begin
                    c = (m == 0) ? k : (lg[m] + 1 + k) % 4;
                    if (g < 0 && sz[c] > 0) g = c;
                end
                if (g < 0) begin
                    exp_udf[m] = 1'b1;
                end else begin
                    it.ch   = 2'(g);
                    it.data = mq[m][g].pop_front();
                    sb[m].push_back(it);
                    lg[m]        = g;
                    m_dout[m]    = it.data;
                    m_ch[m]      = it.ch;
                    exp_valid[m] = 1'b1;
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (wr[k]) begin
                    if (sz[k] == 8) exp_ovf[m][k] = 1'b1;
                    else mq[m][k].push_back(d[k*16 +: 16]);
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            chk("dout_hold", m, 32'(dout_w[m]), 32'(m_dout[m]));
            chk("dout_ch", m, 32'(dout_ch_w[m]), 32'(m_ch[m]));
            chk("dout_valid", m, 32'(dout_valid_w[m]), 32'(exp_valid[m]));
            chk("overflow", m, 32'(overflow_w[m]), 32'(exp_ovf[m]));
            chk("underflow", m, 32'(underflow_w[m]), 32'(exp_udf[m]));
            for (int c = 0; c < 4; c++) begin
                int n;
                n = mq[m][c].size();
                chk("count", m, 32'(count_w[m][c*4 +: 4]), 32'(n));
                chk("empty", m, 32'(empty_w[m][c]), 32'(n == 0));
                chk("full", m, 32'(full_w[m][c]), 32'(n == 8));
                chk("almost_full", m, 32'(af_w[m][c]), 32'(n >= 6));
            end
        end
    endtask

    task automatic cycle(input logic [3:0] wr, input logic [63:0] d, input logic rd);
        @(negedge clk);
        check_outputs();
        wr_en = wr;
        din   = d;
        rd_en = rd;
        model_step(wr, d, rd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        wr_en = '0;
        rd_en = 1'b0;
        rst   = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            chk("rst_empty", m, 32'(empty_w[m]), 32'hF);
            chk("rst_full", m, 32'(full_w[m]), 32'h0);
            chk("rst_af", m, 32'(af_w[m]), 32'h0);
            chk("rst_count", m, 32'(count_w[m]), 32'h0);
            chk("rst_dout", m, 32'(dout_w[m]), 32'h0);
            chk("rst_dout_valid", m, 32'(dout_valid_w[m]), 32'h0);
            chk("rst_underflow", m, 32'(underflow_w[m]), 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin : monitor
        rd_item_t it;
        forever begin
            @(posedge clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (dout_valid_w[m]) begin
                    if (sb[m].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_unexpected inst%0d: got read %0h/ch%0d, expected no read", m, dout_w[m], dout_ch_w[m]);
                    end else begin
                        it = sb[m].pop_front();
                        chk("rd_data", m, 32'(dout_w[m]), 32'(it.data));
                        chk("rd_ch", m, 32'(dout_ch_w[m]), 32'(it.ch));
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [3:0]  w;
        logic [63:0] d;
        logic        r;
        model_reset();

        do_reset();
        cycle(4'b0000, '0, 1'b1);
        cycle(4'b0000, '0, 1'b0);

        // Priority ordering.
        do_reset();
        cycle(4'b0100, {16'h0, 16'h2222, 32'h0}, 1'b0);
        cycle(4'b0001, {48'h0, 16'h0A0A}, 1'b0);
        cycle(4'b0010, {32'h0, 16'h1111, 16'h0}, 1'b0);
        for (int k = 0; k < 4; k++) cycle(4'b0000, '0, 1'b1);
        cycle(4'b0000, '0, 1'b0);

        // Round-robin fairness across all channels.
        do_reset();
        for (int k = 0; k < 2; k++)
            cycle(4'b1111, {16'(16'h30 + k), 16'(16'h20 + k), 16'(16'h10 + k), 16'(k)}, 1'b0);
        for (int k = 0; k < 8; k++) cycle(4'b0000, '0, 1'b1);
        cycle(4'b0000, '0, 1'b0);

        // Fill ch1, overflow with 0xDEAD, drain.
        do_reset();
        for (int k = 0; k < 8; k++) cycle(4'b0010, {32'h0, 16'(16'h1100 + k), 16'h0}, 1'b0);
        cycle(4'b0010, {32'h0, 16'hDEAD, 16'h0}, 1'b0);
        for (int k = 0; k < 9; k++) cycle(4'b0000, '0, 1'b1);
        cycle(4'b0000, '0, 1'b0);

        // Write+read on a full channel; write+read on an all-empty FIFO.
        do_reset();
        for (int k = 0; k < 8; k++) cycle(4'b0001, {48'h0, 16'(16'h0500 + k)}, 1'b0);
        cycle(4'b0001, {48'h0, 16'hBEEF}, 1'b1);
        for (int k = 0; k < 7; k++) cycle(4'b0000, '0, 1'b1);
        cycle(4'b1000, {16'h3333, 48'h0}, 1'b1);
        cycle(4'b0000, '0, 1'b1);
        cycle(4'b0000, '0, 1'b0);

        // Pointer wrap on ch2.
        do_reset();
        for (int k = 0; k < 20; k++) cycle(4'b0100, {16'h0, 16'(16'h2000 + k), 32'h0}, 1'b1);
        cycle(4'b0000, '0, 1'b1);
        cycle(4'b0000, '0, 1'b0);

        // Random traffic: write-heavy, reset with data queued, then read-heavy.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            w = 4'($urandom);
            d = {$urandom, $urandom};
            r = ($urandom_range(0, 3) == 0);
            cycle(w, d, r);
        end
        do_reset();
        for (int k = 0; k < 60; k++) begin
            w = 4'($urandom);
            d = {$urandom, $urandom};
            cycle(w, d, 1'b0);
        end
        for (int k = 0; k < 300; k++) begin
            w = 4'($urandom) & 4'($urandom);
            d = {$urandom, $urandom};
            r = ($urandom_range(0, 3) != 0);
            cycle(w, d, r);
        end
        cycle(4'b0000, '0, 1'b0);
        cycle(4'b0000, '0, 1'b0);
        for (int m = 0; m < 2; m++) chk("sb_drain", m, 32'(sb[m].size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_ch_prio_fifo.md
Name: multi_ch_prio_fifo

Overview:
- Multi-channel synchronous FIFO: NUM_CH independent write queues sharing one read port.
- Next generation of the two-queue high/low priority FIFO: channel count, arbitration mode and thresholds are parameters; adds per-channel occupancy, almost-full flags, output valid/channel tag and overflow/underflow pulses.
- Sits between several producers (e.g. per-source packet/command generators) and a single consumer.

Parameters:
- DATA_WIDTH, 16, data word width.
- DEPTH, 8, entries per channel; power of two, >= 2.
- ADDR_WIDTH, 3, log2(DEPTH).
- NUM_CH, 4, number of channels; >= 2.
- CH_W, 2, log2(NUM_CH); >= 1.
- ARB_MODE, 0, read arbitration: 0 = strict priority (channel 0 highest), 1 = round-robin.
- AF_THRESH, 6, almost-full threshold in entries; 1..DEPTH.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-low reset.
- wr_en, input, NUM_CH, per-channel write request; bit i for channel i.
- din, input, NUM_CH*DATA_WIDTH, write data; channel i at din[i*DATA_WIDTH +: DATA_WIDTH].
- rd_en, input, 1, read request.
- dout, output, DATA_WIDTH, registered read data.
- dout_valid, output, 1, high for one cycle when dout carries newly read data.
- dout_ch, output, CH_W, source channel of the current dout.
- empty, output, NUM_CH, per-channel empty flag.
- full, output, NUM_CH, per-channel full flag.
- almost_full, output, NUM_CH, per-channel flag: count >= AF_THRESH.
- count, output, NUM_CH*(ADDR_WIDTH+1), per-channel occupancy, 0..DEPTH.
- overflow, output, NUM_CH, one-cycle pulse: write attempted while full.
- underflow, output, 1, one-cycle pulse: rd_en while all channels empty.

Behaviour:
- Storage: per channel, DEPTH x DATA_WIDTH memory; write/read pointers ADDR_WIDTH+1 bits wide (extra MSB = wrap bit). Memory is not reset.
- Flags are combinational from the pointers: empty = pointers equal; full = MSBs differ and address bits equal; count = wr_ptr - rd_ptr modulo 2^(ADDR_WIDTH+1).
- Write: if wr_en[i] and !full[i], store din slice at wr_ptr[i] and increment it. If full[i], drop the word, leave the pointer unchanged, pulse overflow[i] next cycle. Channels write independently; all may write in the same cycle.
- Read: if rd_en and at least one channel is non-empty, the arbiter grants exactly one channel g. On the next edge: dout = head of g, dout_ch = g, dout_valid = 1, rd_ptr[g] increments. Latency is 1 cycle from rd_en to dout_valid.
- If rd_en and all channels are empty: no pointer change, dout and dout_ch hold, dout_valid = 0, underflow pulses. When there is no read, dout_valid = 0 and dout/dout_ch hold.
- Strict priority (ARB_MODE=0): grant the lowest-index non-empty channel.
- Round-robin (ARB_MODE=1): register last_grant (CH_W bits). Search channels cyclically starting at last_grant+1, wrapping NUM_CH-1 -> 0; grant the first non-empty one. last_grant updates only on an actual grant. Reset value of last_grant is NUM_CH-1, so channel 0 is checked first.
- Flags are sampled before the edge:
  - Write to an empty channel in the same cycle as rd_en: that channel is not eligible this cycle.
  - Write to a full channel in the same cycle as a read from that channel: the write is dropped and overflow pulses.
- Pointer wrap: address bits wrap DEPTH-1 -> 0 and the MSB toggles; full/empty stay correct across unlimited wraps.
- Reset (asynchronous, any time, including mid-burst):
  - all pointers = 0, dout = 0, dout_ch = 0, dout_valid = 0, overflow = 0, underflow = 0, last_grant = NUM_CH-1.
  - Hence empty = all ones, full = 0, almost_full = 0, count = 0.
  - Contents queued before reset are lost.
  - The first rising edge after reset release behaves normally.

Test Plan:
- Reset/idle (NUM_CH=4, DEPTH=8): assert rst low mid-traffic -> immediately empty=4'b1111, full=0, counts=0, dout=0, dout_valid=0; rd_en=1 afterwards -> underflow=1 for one cycle, dout_valid=0.
- Strict priority (ARB_MODE=0): write ch2 0x2222, ch0 0x0A0A, ch1 0x1111, then rd_en for 4 cycles -> dout/dout_ch sequence 0x0A0A/0, 0x1111/1, 0x2222/2, each with dout_valid=1; 4th read -> underflow pulse.
- Round-robin (ARB_MODE=1): 2 words in each of ch0..ch3 (ch i data 0xi0, 0xi1), then 8 back-to-back reads -> dout_ch 0,1,2,3,0,1,2,3 with data 0x00,0x10,0x20,0x30,0x01,0x11,0x21,0x31.
- Full/overflow/almost-full on ch1: write 8 words -> almost_full[1] rises at count=6, full[1]=1 at count=8; 9th write 0xDEAD -> overflow[1] pulse, count stays 8, 0xDEAD never read out.
- Simultaneous events: ch0 full, write plus read same cycle -> write dropped, overflow[0]=1, count 8->7; ch3 empty, write plus rd_en with all others empty -> underflow=1, no read, next-cycle read returns the new word.
- Wrap-around: 20 write/read pairs on ch2 at DEPTH=8 -> data returned in order, empty/full correct across pointer wraps, count returns to 0.
